// File: rtl/seg7_scan_ctrl_if.sv
// Write port and display-drive signals of the 4-digit multiplexed 7-segment scan controller.
// master = writer/board side, slave = scan controller.
interface seg7_scan_ctrl_if;
  logic        enable;
  logic        wr_en;
  logic [15:0] wr_data;
  logic [3:0]  wr_dp;
  logic        wr_ack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_done;

  modport master (
    output enable, wr_en, wr_data, wr_dp,
    input  wr_ack, an, seg, dp, frame_done
  );

  modport slave (
    input  enable, wr_en, wr_data, wr_dp,
    output wr_ack, an, seg, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 4-digit multiplexed 7-segment scan controller with a pending/display register pair.
// New values are committed only at the digit 3 -> 0 wrap, so a frame is never torn.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter bit BLANK_LZ = 1'b1
) (
  input logic             clk,
  input logic             reset,
  seg7_scan_ctrl_if.slave bus
);

  localparam int            CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [1:0]    idx_r;
  logic [15:0]   disp_r;
  logic [3:0]    disp_dp_r;
  logic [15:0]   pend_data_r;
  logic [3:0]    pend_dp_r;
  logic          pend_valid_r;
  logic          wr_ack_r;
  logic          frame_done_r;
  logic [3:0]    an_r;
  logic [6:0]    seg_r;
  logic          dp_r;

  logic          tick_s;
  logic          wrap_s;
  logic          commit_s;
  logic [CW-1:0] cnt_n_s;
  logic [1:0]    idx_n_s;
  logic [15:0]   disp_n_s;
  logic [3:0]    disp_dp_n_s;
  logic [3:0]    nib_s;
  logic [3:0]    an_n_s;
  logic [6:0]    seg_n_s;
  logic          dp_n_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg_v;
    case (nib)
      4'h0: seg_v = 7'h40;
      4'h1: seg_v = 7'h79;
      4'h2: seg_v = 7'h24;
      4'h3: seg_v = 7'h30;
      4'h4: seg_v = 7'h19;
      4'h5: seg_v = 7'h12;
      4'h6: seg_v = 7'h02;
      4'h7: seg_v = 7'h78;
      4'h8: seg_v = 7'h00;
      4'h9: seg_v = 7'h10;
      4'hA: seg_v = 7'h08;
      4'hB: seg_v = 7'h03;
      4'hC: seg_v = 7'h46;
      4'hD: seg_v = 7'h21;
      4'hE: seg_v = 7'h06;
      4'hF: seg_v = 7'h0E;
      default: seg_v = 7'h7F;
    endcase
    return seg_v;
  endfunction

  // Digit i is a leading zero when it and every digit above it are zero; digit 0 always shows.
  function automatic logic is_blank(input logic [15:0] val, input logic [1:0] digit);
    logic blank_v;
    case (digit)
      2'd3:    blank_v = (val[15:12] == 4'h0);
      2'd2:    blank_v = (val[15:8] == 8'h00);
      2'd1:    blank_v = (val[15:4] == 12'h000);
      default: blank_v = 1'b0;
    endcase
    return BLANK_LZ && blank_v;
  endfunction

  // Next-state scan position, commit decision and next display drive.
  always_comb begin
    tick_s      = 1'b0;
    wrap_s      = 1'b0;
    commit_s    = 1'b0;
    cnt_n_s     = cnt_r;
    idx_n_s     = idx_r;
    disp_n_s    = disp_r;
    disp_dp_n_s = disp_dp_r;
    nib_s       = 4'h0;
    an_n_s      = 4'b1111;
    seg_n_s     = 7'h7F;
    dp_n_s      = 1'b1;

    if (bus.enable && (cnt_r == CNT_LAST)) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
    wrap_s   = tick_s && (idx_r == 2'd3);
    commit_s = wrap_s && pend_valid_r;

    if (!bus.enable) begin
      cnt_n_s = cnt_r;
    end else if (tick_s) begin
      cnt_n_s = '0;
    end else begin
      cnt_n_s = cnt_r + CW'(1);
    end

    if (tick_s) begin
      idx_n_s = idx_r + 2'd1;
    end else begin
      idx_n_s = idx_r;
    end

    if (commit_s) begin
      disp_n_s    = pend_data_r;
      disp_dp_n_s = pend_dp_r;
    end else begin
      disp_n_s    = disp_r;
      disp_dp_n_s = disp_dp_r;
    end

    case (idx_n_s)
      2'd0:    begin an_n_s = 4'b1110; nib_s = disp_n_s[3:0];   end
      2'd1:    begin an_n_s = 4'b1101; nib_s = disp_n_s[7:4];   end
      2'd2:    begin an_n_s = 4'b1011; nib_s = disp_n_s[11:8];  end
      2'd3:    begin an_n_s = 4'b0111; nib_s = disp_n_s[15:12]; end
      default: begin an_n_s = 4'b1111; nib_s = 4'h0;            end
    endcase

    if (is_blank(disp_n_s, idx_n_s)) begin
      seg_n_s = 7'h7F;
    end else begin
      seg_n_s = hex_to_seg(nib_s);
    end
    dp_n_s = ~disp_dp_n_s[idx_n_s];

    if (!bus.enable) begin
      an_n_s  = 4'b1111;
      seg_n_s = 7'h7F;
      dp_n_s  = 1'b1;
    end else begin
      an_n_s  = an_n_s;
    end
  end

  // Prescaler, digit index and the pending/display register pair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r        <= '0;
      idx_r        <= 2'd0;
      disp_r       <= 16'h0000;
      disp_dp_r    <= 4'h0;
      pend_data_r  <= 16'h0000;
      pend_dp_r    <= 4'h0;
      pend_valid_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_n_s;
      idx_r     <= idx_n_s;
      disp_r    <= disp_n_s;
      disp_dp_r <= disp_dp_n_s;
      // A write in the commit cycle lands in pending and waits for the next wrap.
      if (bus.wr_en) begin
        pend_data_r  <= bus.wr_data;
        pend_dp_r    <= bus.wr_dp;
        pend_valid_r <= 1'b1;
      end else if (commit_s) begin
        pend_valid_r <= 1'b0;
      end
    end
  end

  // Registered display drive and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_r         <= 4'b1110;
      seg_r        <= 7'h40;
      dp_r         <= 1'b1;
      wr_ack_r     <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      an_r         <= an_n_s;
      seg_r        <= seg_n_s;
      dp_r         <= dp_n_s;
      wr_ack_r     <= commit_s;
      frame_done_r <= wrap_s;
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.wr_ack     = wr_ack_r;
  assign bus.frame_done = frame_done_r;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-arithmetic reference model queues the expected
// drive for every clock edge and a monitor compares it against two DUTs (BLANK_LZ = 1 and 0).
module tb_seg7_scan_ctrl;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic [6:0] seg_nb;
    logic       dp;
    logic       ack;
    logic       fd;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic cur_en;

  seg7_scan_ctrl_if bus_a ();
  seg7_scan_ctrl_if bus_b ();

  seg7_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
  seg7_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_LZ(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

  always #5 clk = ~clk;

  int   vectors = 0;
  int   fails   = 0;
  exp_t q[$];

  // Reference model: enabled-edge count gives the scan position; disp/pend follow the frame rules.
  int          ecount  = 0;
  logic [15:0] m_disp  = 16'h0000;
  logic [3:0]  m_dpv   = 4'h0;
  logic [15:0] p_data  = 16'h0000;
  logic [3:0]  p_dp    = 4'h0;
  bit          p_valid = 1'b0;

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] ref_seg(input logic [15:0] d, input int i, input bit blz);
    logic [15:0] upper;
    logic [3:0]  nib;
    upper = d >> (4 * i);
    nib   = upper[3:0];
    if (blz && i >= 1 && upper == 16'h0000) return 7'h7F;
    return hex_tab[nib];
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic set_in(input logic en, input logic we, input logic [15:0] d, input logic [3:0] dpv);
    bus_a.enable = en;  bus_a.wr_en = we;  bus_a.wr_data = d;  bus_a.wr_dp = dpv;
    bus_b.enable = en;  bus_b.wr_en = we;  bus_b.wr_data = d;  bus_b.wr_dp = dpv;
  endtask

  // Apply one clock edge: predict its outcome, queue it, then let the edge happen.
  task automatic cyc(input logic en, input logic we, input logic [15:0] d, input logic [3:0] dpv);
    exp_t       e;
    bit         boundary;
    int         idx;
    logic [3:0] one;
    set_in(en, we, d, dpv);
    boundary = en && ((ecount % FRAME) == FRAME - 1);
    e.fd  = boundary;
    e.ack = boundary && p_valid;
    if (boundary && p_valid) begin
      m_disp  = p_data;
      m_dpv   = p_dp;
      p_valid = 1'b0;
    end
    if (we) begin
      p_data  = d;
      p_dp    = dpv;
      p_valid = 1'b1;
    end
    if (en) ecount++;
    idx = (ecount / DIV) % 4;
    one = 4'b0001;
    if (en) begin
      e.an     = ~(one << idx);
      e.seg    = ref_seg(m_disp, idx, 1'b1);
      e.seg_nb = ref_seg(m_disp, idx, 1'b0);
      e.dp     = ~m_dpv[idx];
    end else begin
      e.an     = 4'b1111;
      e.seg    = 7'h7F;
      e.seg_nb = 7'h7F;
      e.dp     = 1'b1;
    end
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cyc(cur_en, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic wait_idx(input int target);
    while (((ecount / DIV) % 4) != target) cyc(1'b1, 1'b0, 16'h0000, 4'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_an"},  8'(bus_a.an),         8'h0E);
    chk({tag, "_seg"}, 8'(bus_a.seg),        8'h40);
    chk({tag, "_dp"},  8'(bus_a.dp),         8'h01);
    chk({tag, "_ack"}, 8'(bus_a.wr_ack),     8'h00);
    chk({tag, "_fd"},  8'(bus_a.frame_done), 8'h00);
    chk({tag, "_segb"}, 8'(bus_b.seg),       8'h40);
  endtask

  task automatic model_reset();
    ecount  = 0;
    m_disp  = 16'h0000;
    m_dpv   = 4'h0;
    p_valid = 1'b0;
  endtask

  // Monitor: compares both DUTs against the queued prediction after every edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("an",         8'(bus_a.an),         8'(e.an));
        chk("seg",        8'(bus_a.seg),        8'(e.seg));
        chk("dp",         8'(bus_a.dp),         8'(e.dp));
        chk("wr_ack",     8'(bus_a.wr_ack),     8'(e.ack));
        chk("frame_done", 8'(bus_a.frame_done), 8'(e.fd));
        chk("seg_nolz",   8'(bus_b.seg),        8'(e.seg_nb));
        chk("an_nolz",    8'(bus_b.an),         8'(e.an));
      end
    end
  end

  initial begin
    logic [15:0] d;
    cur_en = 1'b1;
    set_in(1'b1, 1'b0, 16'h0000, 4'h0);
    #1 reset = 1'b1;
    #2 check_reset_outputs("reset");
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    model_reset();

    // Idle scan: digit 0 shows 0, upper digits blank, no acks.
    run(3 * FRAME);

    // Single write mid-frame.
    wait_idx(1);
    cyc(1'b1, 1'b1, 16'h12AF, 4'b0001);
    run(2 * FRAME);

    // Two writes in one frame: last wins, one ack.
    wait_idx(1);
    cyc(1'b1, 1'b1, 16'h1111, 4'b0000);
    cyc(1'b1, 1'b1, 16'h0030, 4'b0000);
    run(2 * FRAME);

    // Drop enable mid-slot of digit 2, then resume.
    wait_idx(2);
    cyc(1'b1, 1'b0, 16'h0000, 4'h0);
    cur_en = 1'b0;
    run(20);
    cur_en = 1'b1;
    run(2 * FRAME);

    // Write in the commit cycle while an older value is pending.
    while ((ecount % FRAME) != 0) cyc(1'b1, 1'b0, 16'h0000, 4'h0);
    cyc(1'b1, 1'b1, 16'hC0DE, 4'b1010);
    while ((ecount % FRAME) != FRAME - 1) cyc(1'b1, 1'b0, 16'h0000, 4'h0);
    cyc(1'b1, 1'b1, 16'h0705, 4'b0100);
    run(2 * FRAME + 3);

    // Randomized traffic with enable toggling and leading-zero-heavy values.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 39) == 0) cur_en = ~cur_en;
      if ($urandom_range(0, 7) == 0) begin
        d = 16'($urandom);
        d = d >> (4 * $urandom_range(0, 4));
        cyc(cur_en, 1'b1, d, 4'($urandom));
      end else begin
        cyc(cur_en, 1'b0, 16'h0000, 4'h0);
      end
    end
    cur_en = 1'b1;

    // Mid-frame async reset with BEEF displayed and another write pending.
    wait_idx(1);
    cyc(1'b1, 1'b1, 16'hBEEF, 4'b1111);
    run(2 * FRAME);
    wait_idx(2);
    cyc(1'b1, 1'b0, 16'h0000, 4'h0);
    cyc(1'b1, 1'b1, 16'h4321, 4'b0011);
    #1 reset = 1'b1;
    #1 check_reset_outputs("async_reset");
    model_reset();
    set_in(1'b1, 1'b0, 16'h0000, 4'h0);
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    run(3 * FRAME);

    #20;
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
